// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: host strobe synchroniser/glitch filter, in-order command FIFO
// and req/ack issue engine feeding the VDP core from the pixel clock domain.
module vdp_cpu_port #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk_w,
    input  logic                        reset_n_w,
    input  logic                        csr_n,
    input  logic                        csw_n,
    input  logic [ADDR_W-1:0]           mode,
    input  logic [DATA_W-1:0]           cd_i,
    output logic [DATA_W-1:0]           cd_o,
    output logic                        cd_oe,
    output logic                        req,
    output logic                        wrt,
    output logic [ADDR_W-1:0]           adr,
    output logic [DATA_W-1:0]           dbo,
    input  logic                        ack,
    input  logic [DATA_W-1:0]           dbi,
    input  logic                        ovf_clr,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic {IDLE, REQ} state_t;

    logic [1:0]                  strb_n;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]                  filt_q, filt_d, prev_q, prev_d, fall;
    logic                        rd_ev, wr_ev, push, pop, full, push_ok, drop;
    logic [ENT_W-1:0]            mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic                        overflow_q, overflow_d;
    state_t                      state_q, state_d;
    logic                        req_q, req_d, wrt_q, wrt_d;
    logic [ADDR_W-1:0]           adr_q, adr_d;
    logic [DATA_W-1:0]           dbo_q, dbo_d, cd_o_q, cd_o_d;
    logic                        h_wrt;
    logic [ADDR_W-1:0]           h_adr;
    logic [DATA_W-1:0]           h_dat;

    // bit 0 carries the read strobe, bit 1 the write strobe
    assign strb_n = {csw_n, csr_n};

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            sync_d[s] = {sync_q[s][SYNC_STAGES-2:0], strb_n[s]};
            filt_d[s] = filt_q[s];
            cnt_d[s]  = '0;
            if (sync_q[s][SYNC_STAGES-1] != filt_q[s]) begin
                if (cnt_q[s] == CNT_W'(FILTER_LEN - 1))
                    filt_d[s] = ~filt_q[s];
                else
                    cnt_d[s] = cnt_q[s] + CNT_W'(1);
            end
        end
    end

    // a fall only counts while the other filtered strobe is still high
    assign prev_d  = filt_q;
    assign fall    = prev_q & ~filt_q;
    assign rd_ev   = fall[0] & filt_q[1];
    assign wr_ev   = fall[1] & filt_q[0];
    assign push    = rd_ev | wr_ev;
    assign full    = level_q == LVL_W'(FIFO_DEPTH);
    assign pop     = (state_q == REQ) & ack;
    assign push_ok = push & (~full | pop);
    assign drop    = push & ~push_ok;

    always_comb begin
        mem_d = mem_q;
        if (push_ok)
            mem_d[wr_ptr_q] = {wr_ev, mode, cd_i};
    end

    assign wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    assign level_d    = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    assign overflow_d = drop | (overflow_q & ~ovf_clr);
    assign {h_wrt, h_adr, h_dat} = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wrt_d   = wrt_q;
        adr_d   = adr_q;
        dbo_d   = dbo_q;
        cd_o_d  = cd_o_q;
        if (state_q == IDLE) begin
            if (level_q != '0) begin
                wrt_d   = h_wrt;
                adr_d   = h_adr;
                dbo_d   = h_dat;
                req_d   = 1'b1;
                state_d = REQ;
            end
        end else if (ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
            cd_o_d  = wrt_q ? cd_o_q : dbi;
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            sync_q     <= '1;
            filt_q     <= '1;
            prev_q     <= '1;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wrt_q      <= 1'b0;
            adr_q      <= '0;
            dbo_q      <= '0;
            cd_o_q     <= '0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            req_q      <= req_d;
            wrt_q      <= wrt_d;
            adr_q      <= adr_d;
            dbo_q      <= dbo_d;
            cd_o_q     <= cd_o_d;
        end
    end

    assign cd_oe    = ~csr_n;
    assign cd_o     = cd_o_q;
    assign req      = req_q;
    assign wrt      = wrt_q;
    assign adr      = adr_q;
    assign dbo      = dbo_q;
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule
